// File: rtl/date_counter.sv
// rtl/date_counter.sv - calendar date register with Gregorian rollover and validated bulk load
module date_counter #(
  parameter logic [11:0] RST_YEAR = 12'd2024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        day_tick,
  input  logic        sync,
  input  logic [3:0]  day10_in,
  input  logic [3:0]  day1_in,
  input  logic [3:0]  month10_in,
  input  logic [3:0]  month1_in,
  input  logic [11:0] year_in,
  output logic [3:0]  day10,
  output logic [3:0]  day1,
  output logic [3:0]  month10,
  output logic [3:0]  month1,
  output logic [11:0] year,
  output logic        new_month,
  output logic        new_year,
  output logic        load_ok,
  output logic        load_err
);

  localparam logic STATE_IDLE  = 1'b0;
  localparam logic STATE_CHECK = 1'b1;

  logic        state_q, state_d;
  logic        pending_q, pending_d;
  logic [4:0]  day_q, day_d;
  logic [3:0]  month_q, month_d;
  logic [11:0] year_q, year_d;
  logic [3:0]  sh_day10_q, sh_day10_d, sh_day1_q, sh_day1_d;
  logic [3:0]  sh_month10_q, sh_month10_d, sh_month1_q, sh_month1_d;
  logic [11:0] sh_year_q, sh_year_d;
  logic [3:0]  day10_q, day10_d, day1_q, day1_d;
  logic [3:0]  month10_q, month10_d, month1_q, month1_d;
  logic        new_month_q, new_month_d, new_year_q, new_year_d;
  logic        load_ok_q, load_ok_d, load_err_q, load_err_d;

  logic [4:0]  adv_dim, adv_day;
  logic [3:0]  adv_month;
  logic [11:0] adv_year;
  logic        adv_nm, adv_ny;
  logic [6:0]  sh_month;
  logic [7:0]  sh_day;
  logic [4:0]  sh_dim, sh_day_clamped;
  logic        sh_valid;

  function automatic logic [4:0] days_in_month(input logic [3:0] m, input logic [11:0] y);
    logic leap;
    leap = (((y % 12'd4) == 12'd0) && ((y % 12'd100) != 12'd0)) || ((y % 12'd400) == 12'd0);
    case (m)
      4'd4, 4'd6, 4'd9, 4'd11: days_in_month = 5'd30;
      4'd2:                    days_in_month = leap ? 5'd29 : 5'd28;
      default:                 days_in_month = 5'd31;
    endcase
  endfunction

  // Tens/ones split by range compare; days never exceed 31, months never exceed 12.
  function automatic logic [7:0] day_to_bcd(input logic [4:0] v);
    logic [4:0] ones;
    if (v >= 5'd30) begin
      ones = v - 5'd30;
      day_to_bcd = {4'd3, ones[3:0]};
    end else if (v >= 5'd20) begin
      ones = v - 5'd20;
      day_to_bcd = {4'd2, ones[3:0]};
    end else if (v >= 5'd10) begin
      ones = v - 5'd10;
      day_to_bcd = {4'd1, ones[3:0]};
    end else begin
      day_to_bcd = {4'd0, v[3:0]};
    end
  endfunction

  function automatic logic [7:0] month_to_bcd(input logic [3:0] v);
    month_to_bcd = (v >= 4'd10) ? {4'd1, v - 4'd10} : {4'd0, v};
  endfunction

  always_comb begin
    adv_dim   = days_in_month(month_q, year_q);
    adv_day   = day_q + 5'd1;
    adv_month = month_q;
    adv_year  = year_q;
    adv_nm    = 1'b0;
    adv_ny    = 1'b0;
    if (day_q >= adv_dim) begin
      adv_day = 5'd1;
      adv_nm  = 1'b1;
      if (month_q == 4'd12) begin
        adv_month = 4'd1;
        adv_year  = year_q + 12'd1;
        adv_ny    = 1'b1;
      end else begin
        adv_month = month_q + 4'd1;
      end
    end
  end

  always_comb begin
    sh_month = {3'b000, sh_month10_q} * 7'd10 + {3'b000, sh_month1_q};
    sh_day   = {4'b0000, sh_day10_q} * 8'd10 + {4'b0000, sh_day1_q};
    sh_dim   = days_in_month(sh_month[3:0], sh_year_q);
    sh_valid = (sh_day10_q <= 4'd3) && (sh_day1_q <= 4'd9) &&
               (sh_month10_q <= 4'd9) && (sh_month1_q <= 4'd9) &&
               (sh_month != 7'd0) && (sh_month <= 7'd12) && (sh_day != 8'd0);
    sh_day_clamped = (sh_day > {3'b000, sh_dim}) ? sh_dim : sh_day[4:0];
  end

  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    day_d        = day_q;
    month_d      = month_q;
    year_d       = year_q;
    sh_day10_d   = sh_day10_q;
    sh_day1_d    = sh_day1_q;
    sh_month10_d = sh_month10_q;
    sh_month1_d  = sh_month1_q;
    sh_year_d    = sh_year_q;
    new_month_d  = 1'b0;
    new_year_d   = 1'b0;
    load_ok_d    = 1'b0;
    load_err_d   = 1'b0;
    case (state_q)
      STATE_IDLE: begin
        // A held tick wins over a fresh one, so at most one tick is ever queued.
        if (pending_q || day_tick) begin
          day_d       = adv_day;
          month_d     = adv_month;
          year_d      = adv_year;
          new_month_d = adv_nm;
          new_year_d  = adv_ny;
          pending_d   = 1'b0;
        end
        if (sync) begin
          sh_day10_d   = day10_in;
          sh_day1_d    = day1_in;
          sh_month10_d = month10_in;
          sh_month1_d  = month1_in;
          sh_year_d    = year_in;
          state_d      = STATE_CHECK;
          if (day_tick) begin
            day_d       = pending_q ? adv_day : day_q;
            month_d     = pending_q ? adv_month : month_q;
            year_d      = pending_q ? adv_year : year_q;
            new_month_d = pending_q & adv_nm;
            new_year_d  = pending_q & adv_ny;
            pending_d   = 1'b1;
          end
        end
      end
      default: begin
        if (day_tick) begin
          pending_d = 1'b1;
        end
        if (sh_valid) begin
          day_d     = sh_day_clamped;
          month_d   = sh_month[3:0];
          year_d    = sh_year_q;
          load_ok_d = 1'b1;
        end else begin
          load_err_d = 1'b1;
        end
        state_d = STATE_IDLE;
      end
    endcase
    {day10_d, day1_d}     = day_to_bcd(day_d);
    {month10_d, month1_d} = month_to_bcd(month_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= STATE_IDLE;
      pending_q    <= 1'b0;
      day_q        <= 5'd1;
      month_q      <= 4'd1;
      year_q       <= RST_YEAR;
      sh_day10_q   <= 4'd0;
      sh_day1_q    <= 4'd0;
      sh_month10_q <= 4'd0;
      sh_month1_q  <= 4'd0;
      sh_year_q    <= 12'd0;
      day10_q      <= 4'd0;
      day1_q       <= 4'd1;
      month10_q    <= 4'd0;
      month1_q     <= 4'd1;
      new_month_q  <= 1'b0;
      new_year_q   <= 1'b0;
      load_ok_q    <= 1'b0;
      load_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      day_q        <= day_d;
      month_q      <= month_d;
      year_q       <= year_d;
      sh_day10_q   <= sh_day10_d;
      sh_day1_q    <= sh_day1_d;
      sh_month10_q <= sh_month10_d;
      sh_month1_q  <= sh_month1_d;
      sh_year_q    <= sh_year_d;
      day10_q      <= day10_d;
      day1_q       <= day1_d;
      month10_q    <= month10_d;
      month1_q     <= month1_d;
      new_month_q  <= new_month_d;
      new_year_q   <= new_year_d;
      load_ok_q    <= load_ok_d;
      load_err_q   <= load_err_d;
    end
  end

  assign day10     = day10_q;
  assign day1      = day1_q;
  assign month10   = month10_q;
  assign month1    = month1_q;
  assign year      = year_q;
  assign new_month = new_month_q;
  assign new_year  = new_year_q;
  assign load_ok   = load_ok_q;
  assign load_err  = load_err_q;

endmodule

// File: tb/tb_date_counter.sv
// tb/tb_date_counter.sv - scoreboard bench for date_counter
module tb_date_counter;
  logic        clk = 1'b0;
  logic        reset, day_tick, sync;
  logic [3:0]  day10_in, day1_in, month10_in, month1_in;
  logic [11:0] year_in;
  logic [3:0]  day10, day1, month10, month1;
  logic [11:0] year;
  logic        new_month, new_year, load_ok, load_err;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];
  int cur_y, cur_m, cur_d;

  always #5 clk = ~clk;

  date_counter #(.RST_YEAR(12'd2024)) dut (
    .clk(clk), .reset(reset), .day_tick(day_tick), .sync(sync),
    .day10_in(day10_in), .day1_in(day1_in), .month10_in(month10_in), .month1_in(month1_in),
    .year_in(year_in),
    .day10(day10), .day1(day1), .month10(month10), .month1(month1), .year(year),
    .new_month(new_month), .new_year(new_year), .load_ok(load_ok), .load_err(load_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pack(input int y, input int m, input int d,
                                       input logic nm, input logic ny, input logic ok, input logic err);
    logic [11:0] yy;
    logic [3:0]  m10, m1, d10, d1;
    yy  = 12'(y);
    m10 = 4'(m / 10);
    m1  = 4'(m % 10);
    d10 = 4'(d / 10);
    d1  = 4'(d % 10);
    return {yy, m10, m1, d10, d1, nm, ny, ok, err};
  endfunction

  function automatic logic [31:0] observed();
    return {year, month10, month1, day10, day1, new_month, new_year, load_ok, load_err};
  endfunction

  function automatic int tb_dim(input int y, input int m);
    int len[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    if (m == 2 && ((y % 400 == 0) || (y % 4 == 0 && y % 100 != 0))) return 29;
    return len[m-1];
  endfunction

  task automatic step(input string tag, input logic tk, input logic sy, input int yy,
                      input logic [3:0] m10, input logic [3:0] m1, input logic [3:0] d10,
                      input logic [3:0] d1, input logic [31:0] e);
    day_tick   = tk;
    sync       = sy;
    year_in    = 12'(yy);
    month10_in = m10;
    month1_in  = m1;
    day10_in   = d10;
    day1_in    = d1;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clk);
    check_eq(tag_q.pop_front(), observed(), exp_q.pop_front());
    day_tick = 1'b0;
    sync     = 1'b0;
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 1'b0, 0, 4'd0, 4'd0, 4'd0, 4'd0, pack(cur_y, cur_m, cur_d, 1'b0, 1'b0, 1'b0, 1'b0));
  endtask

  task automatic tick(input string tag);
    logic nm, ny;
    nm = 1'b0;
    ny = 1'b0;
    if (cur_d < tb_dim(cur_y, cur_m)) begin
      cur_d++;
    end else begin
      cur_d = 1;
      nm = 1'b1;
      if (cur_m == 12) begin
        cur_m = 1;
        ny = 1'b1;
        cur_y = (cur_y + 1) % 4096;
      end else begin
        cur_m++;
      end
    end
    step(tag, 1'b1, 1'b0, 0, 4'd0, 4'd0, 4'd0, 4'd0, pack(cur_y, cur_m, cur_d, nm, ny, 1'b0, 1'b0));
  endtask

  task automatic load(input string tag, input int yy, input logic [3:0] m10, input logic [3:0] m1,
                      input logic [3:0] d10, input logic [3:0] d1,
                      input logic ok, input int ey, input int em, input int ed);
    step({tag, "_cap"}, 1'b0, 1'b1, yy, m10, m1, d10, d1,
         pack(cur_y, cur_m, cur_d, 1'b0, 1'b0, 1'b0, 1'b0));
    if (ok) begin
      cur_y = ey;
      cur_m = em;
      cur_d = ed;
    end
    step({tag, "_res"}, 1'b0, 1'b0, 0, 4'd0, 4'd0, 4'd0, 4'd0,
         pack(cur_y, cur_m, cur_d, 1'b0, 1'b0, ok, !ok));
  endtask

  initial begin
    reset = 1'b1;
    day_tick = 1'b0;
    sync = 1'b0;
    year_in = 12'd0;
    month10_in = 4'd0;
    month1_in = 4'd0;
    day10_in = 4'd0;
    day1_in = 4'd0;
    cur_y = 2024;
    cur_m = 1;
    cur_d = 1;
    repeat (2) @(negedge clk);
    idle("reset_state");
    reset = 1'b0;

    for (int i = 0; i < 59; i++) tick("tick_jan_feb");
    check_eq("leap_day", observed(), pack(2024, 2, 29, 1'b0, 1'b0, 1'b0, 1'b0));
    tick("to_mar01");
    idle("nm_one_cycle");

    load("ld_2023", 2023, 4'd0, 4'd2, 4'd2, 4'd8, 1'b1, 2023, 2, 28);
    tick("nonleap_2023");
    load("ld_1900", 1900, 4'd0, 4'd2, 4'd2, 4'd8, 1'b1, 1900, 2, 28);
    tick("nonleap_1900");
    load("ld_2000", 2000, 4'd0, 4'd2, 4'd2, 4'd8, 1'b1, 2000, 2, 28);
    tick("leap_2000");
    load("ld_dec31", 2024, 4'd1, 4'd2, 4'd3, 4'd1, 1'b1, 2024, 12, 31);
    tick("new_year_2025");
    idle("ny_one_cycle");
    load("ld_4095", 4095, 4'd1, 4'd2, 4'd3, 4'd1, 1'b1, 4095, 12, 31);
    tick("year_wrap");

    load("bad_month13", 2024, 4'd1, 4'd3, 4'd0, 4'd1, 1'b0, 0, 0, 0);
    load("bad_month0", 2024, 4'd0, 4'd0, 4'd0, 4'd1, 1'b0, 0, 0, 0);
    load("bad_day1_a", 2024, 4'd0, 4'd1, 4'd0, 4'ha, 1'b0, 0, 0, 0);
    load("bad_day0", 2024, 4'd0, 4'd1, 4'd0, 4'd0, 1'b0, 0, 0, 0);
    load("bad_day10_4", 2024, 4'd0, 4'd1, 4'd4, 4'd0, 1'b0, 0, 0, 0);
    load("clamp_feb30", 2023, 4'd0, 4'd2, 4'd3, 4'd0, 1'b1, 2023, 2, 28);
    load("clamp_apr31", 2024, 4'd0, 4'd4, 4'd3, 4'd1, 1'b1, 2024, 4, 30);

    step("sync_tick_cap", 1'b1, 1'b1, 2024, 4'd0, 4'd6, 4'd1, 4'd5,
         pack(cur_y, cur_m, cur_d, 1'b0, 1'b0, 1'b0, 1'b0));
    step("sync_tick_load", 1'b1, 1'b0, 0, 4'd0, 4'd0, 4'd0, 4'd0,
         pack(2024, 6, 15, 1'b0, 1'b0, 1'b1, 1'b0));
    step("pending_apply", 1'b1, 1'b0, 0, 4'd0, 4'd0, 4'd0, 4'd0,
         pack(2024, 6, 16, 1'b0, 1'b0, 1'b0, 1'b0));
    cur_y = 2024;
    cur_m = 6;
    cur_d = 16;
    idle("extra_tick_dropped");

    step("rst_cap", 1'b1, 1'b1, 2030, 4'd0, 4'd5, 4'd0, 4'd5,
         pack(cur_y, cur_m, cur_d, 1'b0, 1'b0, 1'b0, 1'b0));
    reset = 1'b1;
    cur_y = 2024;
    cur_m = 1;
    cur_d = 1;
    idle("rst_abort");
    reset = 1'b0;
    idle("rst_no_pulse");
    idle("rst_no_pending");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
